wb_stage_pipe: RTL and testbench

Registered, parametrised write-back stage that sits after the memory stage and drives the register-file write port. It adds several things the combinational write-back path lacks: load-data alignment and sign/zero extension, a one-cycle output pipeline register with stall/flush, sticky halt, and a FWD_DEPTH-entry history of retired writes that answers forwarding queries from decode/execute.

---
 rtl/wb_stage_pipe.sv | 161 ++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage_pipe
// Purpose : Registered write-back stage with load alignment/extension, sticky
//           halt and a retired-write history serving forwarding queries.
// Revision: 1.0 - initial release
// ============================================================================
module wb_stage_pipe #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 5,
    parameter  int FWD_DEPTH = 2,
    localparam int OFF_W     = $clog2(DATA_W / 8)
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iValid,
    input  logic              iStall,
    input  logic              iFlush,
    input  logic [DATA_W-1:0] iMemData,
    input  logic [DATA_W-1:0] iExuData,
    input  logic [ADDR_W-1:0] iWriteAddr,
    input  logic              iWriteEn,
    input  logic              iMemToReg,
    input  logic [1:0]        iLoadSize,
    input  logic              iLoadSigned,
    input  logic [OFF_W-1:0]  iByteOff,
    input  logic              iRetCmd,
    input  logic [DATA_W-1:0] iRetAddr,
    input  logic              iHalt,
    input  logic [ADDR_W-1:0] iFwdAddr,
    output logic [DATA_W-1:0] oWriteData,
    output logic [ADDR_W-1:0] oWriteAddr,
    output logic              oWriteEn,
    output logic              oRetCmd,
    output logic [DATA_W-1:0] oRetAddr,
    output logic              oHalt,
    output logic              oHalted,
    output logic              oFwdHit,
    output logic [DATA_W-1:0] oFwdData
);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    logic              capture;
    logic [DATA_W-1:0] shift_byte;
    logic [DATA_W-1:0] shift_half;
    logic [DATA_W-1:0] shift_word;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       word_val;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] write_data_next;
    logic              write_en_next;

    logic              hist_valid [FWD_DEPTH];
    logic [ADDR_W-1:0] hist_addr  [FWD_DEPTH];
    logic [DATA_W-1:0] hist_data  [FWD_DEPTH];

    assign capture = !iStall && !iFlush && iValid && !oHalted;

    // Lane extraction: shift the addressed lane down to bit 0.
    assign shift_byte = iMemData >> {iByteOff, 3'b000};
    assign shift_half = iMemData >> {iByteOff[OFF_W-1:1], 4'b0000};
    assign byte_val   = shift_byte[7:0];
    assign half_val   = shift_half[15:0];

    generate
        if (OFF_W > 2) begin : g_word_lane
            assign shift_word = iMemData >> {iByteOff[OFF_W-1:2], 5'b00000};
        end else begin : g_word_single
            assign shift_word = iMemData;
        end
    endgenerate

    assign word_val = shift_word[31:0];

    always_comb begin
        load_data = iMemData;
        case (iLoadSize)
            SIZE_BYTE: load_data = iLoadSigned ? DATA_W'($signed(byte_val))
                                               : DATA_W'(byte_val);
            SIZE_HALF: load_data = iLoadSigned ? DATA_W'($signed(half_val))
                                               : DATA_W'(half_val);
            SIZE_WORD: load_data = iLoadSigned ? DATA_W'($signed(word_val))
                                               : DATA_W'(word_val);
            default:   load_data = iMemData;
        endcase
    end

    assign write_data_next = iMemToReg ? load_data : iExuData;
    assign write_en_next   = iWriteEn && (iWriteAddr != '0);

    // Output pipeline register; bubbles hold data/address fields.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oWriteData <= '0;
            oWriteAddr <= '0;
            oWriteEn   <= 1'b0;
            oRetCmd    <= 1'b0;
            oRetAddr   <= '0;
            oHalt      <= 1'b0;
            oHalted    <= 1'b0;
        end else if (capture) begin
            oWriteData <= write_data_next;
            oWriteAddr <= iWriteAddr;
            oWriteEn   <= write_en_next;
            oRetCmd    <= iRetCmd;
            oRetAddr   <= iRetAddr;
            oHalt      <= iHalt;
            oHalted    <= iHalt;
        end else begin
            oWriteEn   <= 1'b0;
            oRetCmd    <= 1'b0;
            oHalt      <= 1'b0;
        end
    end

    // Retired-write history: entry 0 is newest, the last entry ages out.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist_valid[i] <= 1'b0;
                hist_addr[i]  <= '0;
                hist_data[i]  <= '0;
            end
        end else if (oWriteEn) begin
            hist_valid[0] <= 1'b1;
            hist_addr[0]  <= oWriteAddr;
            hist_data[0]  <= oWriteData;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_addr[i]  <= hist_addr[i-1];
                hist_data[i]  <= hist_data[i-1];
            end
        end
    end

    // Scan oldest to newest so the newest match overwrites older ones.
    always_comb begin
        oFwdHit  = 1'b0;
        oFwdData = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (hist_valid[i] && (hist_addr[i] == iFwdAddr)) begin
                oFwdHit  = 1'b1;
                oFwdData = hist_data[i];
            end
        end
        if (oWriteEn && (oWriteAddr == iFwdAddr)) begin
            oFwdHit  = 1'b1;
            oFwdData = oWriteData;
        end
        if (iFwdAddr == '0) begin
            oFwdHit  = 1'b0;
            oFwdData = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage_pipe
// Purpose : Directed self-checking bench for wb_stage_pipe (32-bit, depth 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, stall, flush, write_en, mem_to_reg, load_signed;
    logic        ret_cmd, halt;
    logic [31:0] mem_data, exu_data, ret_addr;
    logic [4:0]  write_addr, fwd_addr;
    logic [1:0]  load_size;
    logic [1:0]  byte_off;
    logic [31:0] o_write_data, o_ret_addr, o_fwd_data;
    logic [4:0]  o_write_addr;
    logic        o_write_en, o_ret_cmd, o_halt, o_halted, o_fwd_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .FWD_DEPTH(2)) dut (
        .iClk(clk), .iReset(rst), .iValid(valid), .iStall(stall), .iFlush(flush),
        .iMemData(mem_data), .iExuData(exu_data), .iWriteAddr(write_addr),
        .iWriteEn(write_en), .iMemToReg(mem_to_reg), .iLoadSize(load_size),
        .iLoadSigned(load_signed), .iByteOff(byte_off), .iRetCmd(ret_cmd),
        .iRetAddr(ret_addr), .iHalt(halt), .iFwdAddr(fwd_addr),
        .oWriteData(o_write_data), .oWriteAddr(o_write_addr), .oWriteEn(o_write_en),
        .oRetCmd(o_ret_cmd), .oRetAddr(o_ret_addr), .oHalt(o_halt),
        .oHalted(o_halted), .oFwdHit(o_fwd_hit), .oFwdData(o_fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exu_write(input logic [4:0] a, input logic [31:0] d);
        valid = 1'b1; write_en = 1'b1; mem_to_reg = 1'b0;
        write_addr = a; exu_data = d;
    endtask

    task automatic load(input logic [1:0] sz, input logic [1:0] off, input logic sgn);
        valid = 1'b1; write_en = 1'b1; mem_to_reg = 1'b1; write_addr = 5'd3;
        mem_data = 32'h80F17F02; load_size = sz; byte_off = off; load_signed = sgn;
    endtask

    initial begin
        rst = 1'b1; valid = 0; stall = 0; flush = 0; write_en = 0; mem_to_reg = 0;
        load_signed = 0; ret_cmd = 0; halt = 0; mem_data = 0; exu_data = 0;
        ret_addr = 0; write_addr = 0; fwd_addr = 0; load_size = 0; byte_off = 0;
        step(); step();
        check("reset_wen",    {31'd0, o_write_en}, 32'd0);
        check("reset_data",   o_write_data, 32'd0);
        check("reset_halted", {31'd0, o_halted}, 32'd0);
        rst = 1'b0;

        // Load alignment and extension
        load(2'd0, 2'd1, 1'b1); ret_cmd = 1'b1; ret_addr = 32'h0000_1000;
        step();
        check("ld_b1_s",   o_write_data, 32'h0000007F);
        check("ld_wen",    {31'd0, o_write_en}, 32'd1);
        check("ld_addr",   {27'd0, o_write_addr}, 32'd3);
        check("ret_cmd",   {31'd0, o_ret_cmd}, 32'd1);
        check("ret_addr",  o_ret_addr, 32'h0000_1000);
        ret_cmd = 1'b0;
        load(2'd0, 2'd2, 1'b1); step(); check("ld_b2_s", o_write_data, 32'hFFFFFFF1);
        check("ret_cmd_clr", {31'd0, o_ret_cmd}, 32'd0);
        load(2'd1, 2'd2, 1'b0); step(); check("ld_h2_u", o_write_data, 32'h000080F1);
        load(2'd1, 2'd2, 1'b1); step(); check("ld_h2_s", o_write_data, 32'hFFFF80F1);
        load(2'd1, 2'd3, 1'b0); step(); check("ld_h3_u", o_write_data, 32'h000080F1);
        load(2'd3, 2'd1, 1'b1); step(); check("ld_full", o_write_data, 32'h80F17F02);
        load(2'd0, 2'd0, 1'b0); step(); check("ld_b0_u", o_write_data, 32'h00000002);

        // Stall x2, flush, then capture; then flush+stall together
        exu_write(5'd5, 32'h11); stall = 1'b1;
        step(); check("stall1_wen", {31'd0, o_write_en}, 32'd0);
        check("stall1_hold", o_write_data, 32'h00000002);
        step(); check("stall2_wen", {31'd0, o_write_en}, 32'd0);
        stall = 1'b0; flush = 1'b1;
        step(); check("flush_wen", {31'd0, o_write_en}, 32'd0);
        flush = 1'b0;
        step();
        check("cap_wen",  {31'd0, o_write_en}, 32'd1);
        check("cap_addr", {27'd0, o_write_addr}, 32'd5);
        check("cap_data", o_write_data, 32'h11);
        flush = 1'b1; stall = 1'b1;
        step(); check("flush_stall_wen", {31'd0, o_write_en}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // r0 suppression
        exu_write(5'd0, 32'hDEAD); step();
        check("r0_wen", {31'd0, o_write_en}, 32'd0);
        fwd_addr = 5'd0; #1;
        check("r0_fwd_hit", {31'd0, o_fwd_hit}, 32'd0);

        // Forwarding history
        exu_write(5'd7, 32'd1); step();
        exu_write(5'd7, 32'd2); step();
        exu_write(5'd9, 32'd3); step();
        fwd_addr = 5'd7; #1;
        check("fwd7_hit",  {31'd0, o_fwd_hit}, 32'd1);
        check("fwd7_data", o_fwd_data, 32'd2);
        fwd_addr = 5'd9; #1;
        check("fwd9_data", o_fwd_data, 32'd3);
        fwd_addr = 5'd5; #1;
        check("fwd5_aged", {31'd0, o_fwd_hit}, 32'd0);
        exu_write(5'd4, 32'd4); step();
        fwd_addr = 5'd7; #1;
        check("fwd7_hit_b",  {31'd0, o_fwd_hit}, 32'd1);
        check("fwd7_data_b", o_fwd_data, 32'd2);
        exu_write(5'd4, 32'd5); step();
        fwd_addr = 5'd7; #1;
        check("fwd7_miss",      {31'd0, o_fwd_hit}, 32'd0);
        check("fwd7_miss_data", o_fwd_data, 32'd0);
        exu_write(5'd4, 32'd6); fwd_addr = 5'd4; #1;
        check("fwd4_newest", o_fwd_data, 32'd5);
        step();
        check("fwd4_after", o_fwd_data, 32'd6);
        valid = 1'b0; step(); step();
        check("fwd4_idle", o_fwd_data, 32'd6);

        // Halt
        exu_write(5'd2, 32'h55); halt = 1'b1; step();
        check("halt_pulse", {31'd0, o_halt}, 32'd1);
        check("halt_wen",   {31'd0, o_write_en}, 32'd1);
        check("halt_data",  o_write_data, 32'h55);
        check("halted",     {31'd0, o_halted}, 32'd1);
        halt = 1'b0; exu_write(5'd6, 32'h66); step();
        check("halt_once",   {31'd0, o_halt}, 32'd0);
        check("halted_wen",  {31'd0, o_write_en}, 32'd0);
        check("halted_hold", {31'd0, o_halted}, 32'd1);
        step();
        check("halted_wen2", {31'd0, o_write_en}, 32'd0);

        // Asynchronous reset mid-cycle
        rst = 1'b1; #1;
        check("areset_data",   o_write_data, 32'd0);
        check("areset_halted", {31'd0, o_halted}, 32'd0);
        check("areset_raddr",  o_ret_addr, 32'd0);
        for (int a = 0; a < 32; a++) begin
            fwd_addr = a[4:0]; #0.1;
            check("areset_fwd_hit", {31'd0, o_fwd_hit}, 32'd0);
        end
        rst = 1'b0;
        step();
        check("post_reset_wen",  {31'd0, o_write_en}, 32'd1);
        check("post_reset_data", o_write_data, 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
